// File: rtl/sample_feeder_pkg.sv
// Shared defaults for the sample feeder: FIFO geometry, period counter width
// and the byte substituted when the FIFO runs dry.
package sample_feeder_pkg;

  localparam int unsigned DEFAULT_FIFO_DEPTH   = 16;
  localparam int unsigned DEFAULT_PERIOD_WIDTH = 16;
  localparam logic [7:0]  DEFAULT_IDLE_SAMPLE  = 8'd0;
  localparam int unsigned SAMPLE_WIDTH         = 8;

endpackage : sample_feeder_pkg

// File: rtl/sample_feeder_fifo.sv
// Synchronous FIFO (sync_fifo role): memory, wrapping pointers, separate
// occupancy counter, full/empty and a synchronous flush that drops a concurrent push.
module sample_feeder_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage has no reset; pointers and level define which entries are valid,
  // and leaving the array unreset lets it map onto plain RAM/flops without reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  end

endmodule : sample_feeder_fifo

// File: rtl/sample_feeder.sv
// Rate-controlled sample source: buffers host bytes and releases one per
// programmable period to the PWM modulator, substituting an idle byte on underrun.
module sample_feeder
  import sample_feeder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
  parameter int unsigned PERIOD_WIDTH = DEFAULT_PERIOD_WIDTH,
  parameter logic [7:0]  IDLE_SAMPLE  = DEFAULT_IDLE_SAMPLE,
  localparam int unsigned LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    flush,
  input  logic [PERIOD_WIDTH-1:0] clks_per_sample,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [7:0]              sample,
  output logic                    new_sample,
  output logic [LW-1:0]           level,
  output logic                    underrun,
  input  logic                    clear_underrun
);

  logic [PERIOD_WIDTH-1:0] count;
  logic [PERIOD_WIDTH-1:0] period;
  logic                    tick;
  logic                    have_data;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic [7:0]              head;

  sample_feeder_fifo #(
    .WIDTH (SAMPLE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (in_valid && in_ready),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // Held low during reset so the host never sees a ready FIFO mid-reset.
  assign in_ready = rst && !full;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    period    = clks_per_sample;
    tick      = 1'b0;
    have_data = 1'b0;
    pop       = 1'b0;
    if (clks_per_sample == '0) period = PERIOD_WIDTH'(1);
    // >= rather than == so a period shortened below the current count ticks next cycle.
    if (enable && (count >= period - PERIOD_WIDTH'(1))) tick = 1'b1;
    // A flush in the same cycle empties the FIFO, so the tick must underrun.
    have_data = !empty && !flush;
    pop       = tick && have_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      sample     <= '0;
      new_sample <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      new_sample <= tick;
      if (!enable || tick) count <= '0;
      else                 count <= count + PERIOD_WIDTH'(1);

      if (tick) sample <= have_data ? head : IDLE_SAMPLE;

      // Set has priority over clear.
      if (tick && !have_data) underrun <= 1'b1;
      else if (clear_underrun) underrun <= 1'b0;
    end
  end

endmodule : sample_feeder

// File: tb/tb_sample_feeder.sv
// Directed self-checking bench for sample_feeder with hand-computed expectations.
module tb_sample_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] clks_per_sample = 16'd4;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  sample;
  logic        new_sample;
  logic [4:0]  level;
  logic        underrun;
  logic        clear_underrun = 1'b0;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  sample_feeder dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .flush           (flush),
    .clks_per_sample (clks_per_sample),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .sample          (sample),
    .new_sample      (new_sample),
    .level           (level),
    .underrun        (underrun),
    .clear_underrun  (clear_underrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int max, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!new_sample && cnt < max);
    if (!new_sample) check("tick_timeout", 32'(new_sample), 32'd1);
  endtask

  task automatic push(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic clear_ur();
    clear_underrun = 1'b1;
    step();
    clear_underrun = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_sample", 32'(sample), 32'h0);
    check("rst_new_sample", 32'(new_sample), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    step();
    rst = 1'b1;
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'h1);

    // Basic output at P=4
    push(8'h10);
    push(8'h20);
    push(8'h30);
    check("basic_level", 32'(level), 32'd3);
    enable = 1'b1;
    wait_tick(20, n);
    check("basic_t0_gap", 32'(n), 32'd4);
    check("basic_t0_sample", 32'(sample), 32'h10);
    wait_tick(20, n);
    check("basic_t1_gap", 32'(n), 32'd4);
    check("basic_t1_sample", 32'(sample), 32'h20);
    wait_tick(20, n);
    check("basic_t2_gap", 32'(n), 32'd4);
    check("basic_t2_sample", 32'(sample), 32'h30);
    check("basic_no_underrun_yet", 32'(underrun), 32'h0);
    wait_tick(20, n);
    check("basic_t3_gap", 32'(n), 32'd4);
    check("basic_t3_sample", 32'(sample), 32'h00);
    check("basic_underrun", 32'(underrun), 32'h1);
    enable = 1'b0;
    clear_ur();
    check("underrun_cleared", 32'(underrun), 32'h0);
    check("disabled_no_strobe", 32'(new_sample), 32'h0);

    // Full FIFO, then 17th byte accepted only after the first pop
    for (int i = 0; i < 16; i++) begin
      in_data  = 8'h40 + 8'(i);
      in_valid = 1'b1;
      step();
    end
    in_data = 8'h50;
    check("full_level", 32'(level), 32'd16);
    check("full_in_ready", 32'(in_ready), 32'h0);
    step();
    step();
    check("full_level_held", 32'(level), 32'd16);
    clks_per_sample = 16'd1;
    enable = 1'b1;
    step();
    check("full_pop_strobe", 32'(new_sample), 32'h1);
    check("full_pop_sample", 32'(sample), 32'h40);
    check("full_pop_level", 32'(level), 32'd15);
    check("full_pop_ready", 32'(in_ready), 32'h1);
    step();
    check("pushpop_sample", 32'(sample), 32'h41);
    check("pushpop_level", 32'(level), 32'd15);
    in_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      check("p1_strobe", 32'(new_sample), 32'h1);
      check("p1_sample", 32'(sample), (k < 14) ? 32'(8'h42 + 8'(k)) : 32'h50);
    end
    enable = 1'b0;
    step();
    check("drain_level", 32'(level), 32'd0);
    check("drain_no_underrun", 32'(underrun), 32'h0);

    // P=0 behaves as P=1
    clks_per_sample = 16'd0;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("p0_strobe", 32'(new_sample), 32'h1);
    end
    enable = 1'b0;
    step();
    clear_ur();

    // Period shortened from 10 to 3 at count 5
    clks_per_sample = 16'd10;
    enable = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check("p10_no_tick", 32'(new_sample), 32'h0);
    clks_per_sample = 16'd3;
    step();
    check("shorten_tick_next", 32'(new_sample), 32'h1);
    wait_tick(20, n);
    check("shorten_then_p3", 32'(n), 32'd3);
    enable = 1'b0;
    step();
    clear_ur();

    // Push on an underrunning tick edge, with clear_underrun asserted too
    clks_per_sample = 16'd2;
    enable = 1'b1;
    step();
    in_data = 8'hA5;
    in_valid = 1'b1;
    clear_underrun = 1'b1;
    step();
    in_valid = 1'b0;
    clear_underrun = 1'b0;
    check("sim_strobe", 32'(new_sample), 32'h1);
    check("sim_idle_sample", 32'(sample), 32'h00);
    check("sim_set_beats_clear", 32'(underrun), 32'h1);
    check("sim_level", 32'(level), 32'd1);
    wait_tick(20, n);
    check("sim_next_gap", 32'(n), 32'd2);
    check("sim_next_sample", 32'(sample), 32'hA5);
    enable = 1'b0;
    step();
    clear_ur();

    // Flush with level 5
    for (int i = 0; i < 5; i++) push(8'h61 + 8'(i));
    check("flush_pre_level", 32'(level), 32'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_sample_kept", 32'(sample), 32'hA5);
    check("flush_underrun_kept", 32'(underrun), 32'h0);
    enable = 1'b1;
    wait_tick(20, n);
    check("flush_tick_sample", 32'(sample), 32'h00);
    check("flush_tick_underrun", 32'(underrun), 32'h1);
    enable = 1'b0;
    step();
    clear_ur();

    // Mid-period asynchronous reset with level 3
    clks_per_sample = 16'd4;
    for (int i = 0; i < 4; i++) push(8'h71 + 8'(i));
    enable = 1'b1;
    wait_tick(20, n);
    check("mr_first_sample", 32'(sample), 32'h71);
    check("mr_level", 32'(level), 32'd3);
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    check("mr_sample", 32'(sample), 32'h0);
    check("mr_new_sample", 32'(new_sample), 32'h0);
    check("mr_level0", 32'(level), 32'h0);
    check("mr_underrun", 32'(underrun), 32'h0);
    check("mr_in_ready", 32'(in_ready), 32'h0);
    enable = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("mr_idle_after", 32'(new_sample), 32'h0);
    enable = 1'b1;
    wait_tick(20, n);
    check("mr_first_tick_gap", 32'(n), 32'd4);
    check("mr_tick_underrun", 32'(underrun), 32'h1);
    enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sample_feeder
